// File: rtl/ysyx_rnu_alloc_arb_pkg.sv
// ysyx_rnu_alloc_arb_pkg: shared RNU allocation types (physical-register width, arbiter state, stall limit)
package ysyx_rnu_alloc_arb_pkg;
    localparam int PHY_LEN = 7;
    localparam logic [15:0] STALL_MAX = 16'hFFFF;
    typedef enum logic {ST_RUN, ST_HOLD} alloc_state_e;
endpackage

// File: rtl/ysyx_rr_arb.sv
// ysyx_rr_arb: round-robin one-hot picker
//   req : request vector     ptr : index that has highest priority
//   en  : grant enable       gnt : one-hot grant (zero when disabled or idle)
//   idx : encoded index of the picked request
module ysyx_rr_arb #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    logic hit;
    logic [IW:0] s;
    always_comb begin
        idx = '0;
        hit = 1'b0;
        s = '0;
        // scan downward so the candidate closest to ptr is assigned last and wins
        for (int k = N - 1; k >= 0; k--) begin
            s = {1'b0, ptr} + (IW + 1)'(k);
            s = s >= (IW + 1)'(N) ? s - (IW + 1)'(N) : s;
            if (req[s[IW-1:0]]) begin
                idx = s[IW-1:0];
                hit = 1'b1;
            end
        end
        gnt = (en & hit) ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/ysyx_rnu_alloc_arb.sv
// ysyx_rnu_alloc_arb: round-robin sharing of the free-list allocation port with flush blocking
//   clock/reset               : clock, async active-low reset
//   req_valid/req_ready       : per-requester request and one-hot combinational grant
//   rsp_valid/rsp_id/rsp_pr   : registered response, one cycle after the grant
//   fl_alloc_req/pr/empty     : free-list allocation port
//   flush_pipe                : level flush; grants blocked during it and HOLD cycles after
//   stall_cnt                 : saturating count of empty-blocked request cycles
module ysyx_rnu_alloc_arb
    import ysyx_rnu_alloc_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PLEN = PHY_LEN,
    parameter int HOLD = 1,
    localparam int IW = $clog2(NREQ)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    output logic            rsp_valid,
    output logic [IW-1:0]   rsp_id,
    output logic [PLEN-1:0] rsp_pr,
    output logic            fl_alloc_req,
    input  logic [PLEN-1:0] fl_alloc_pr,
    input  logic            fl_alloc_empty,
    input  logic            flush_pipe,
    output logic [15:0]     stall_cnt
);
    typedef struct packed {
        logic [IW-1:0]   id;
        logic [PLEN-1:0] pr;
    } rsp_t;
    alloc_state_e  state, state_nxt;
    logic [2:0]    hold_cnt, hold_nxt;
    logic [IW-1:0] rr_ptr, gnt_idx;
    logic          gnt_en, stall;
    rsp_t          rsp;
    assign gnt_en = (state == ST_RUN) & ~flush_pipe & ~fl_alloc_empty;
    assign stall = (state == ST_RUN) & ~flush_pipe & fl_alloc_empty & |req_valid;
    assign fl_alloc_req = |req_ready;
    assign rsp_id = rsp.id;
    assign rsp_pr = rsp.pr;
    ysyx_rr_arb #(.N(NREQ)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .en  (gnt_en),
        .gnt (req_ready),
        .idx (gnt_idx)
    );
    // leaving HOLD on the edge that takes hold_cnt to 0 gives exactly HOLD blocked cycles
    always_comb begin
        state_nxt = state;
        hold_nxt = hold_cnt;
        if (flush_pipe) begin
            state_nxt = ST_HOLD;
            hold_nxt = 3'(HOLD);
        end else if (state == ST_HOLD) begin
            hold_nxt = hold_cnt == 3'd0 ? 3'd0 : hold_cnt - 3'd1;
            state_nxt = hold_cnt <= 3'd1 ? ST_RUN : ST_HOLD;
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            hold_cnt <= '0;
            rr_ptr <= '0;
            rsp_valid <= 1'b0;
            rsp <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            hold_cnt <= hold_nxt;
            rsp_valid <= fl_alloc_req;
            if (fl_alloc_req) begin
                rr_ptr <= gnt_idx == IW'(NREQ - 1) ? '0 : gnt_idx + 1'b1;
                rsp <= '{id: gnt_idx, pr: fl_alloc_pr};
            end
            if (stall && stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule
